// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the accumulator-datapath control sequencer:
// opcodes, write-back selects, state encoding and counter sizing.
package ctrl_seq_pkg;

  localparam logic [3:0] OP_SUB    = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_DIV    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_LSH    = 4'd5;
  localparam logic [3:0] OP_RSH    = 4'd6;
  localparam logic [3:0] OP_GETI   = 4'd7;
  localparam logic [3:0] OP_AND    = 4'd8;
  localparam logic [3:0] OP_SET    = 4'd9;
  localparam logic [3:0] OP_GET    = 4'd10;
  localparam logic [3:0] OP_LOA    = 4'd11;
  localparam logic [3:0] OP_STR    = 4'd12;
  localparam logic [3:0] OP_DONE   = 4'd13;
  localparam logic [3:0] OP_LOOKUP = 4'd14;
  localparam logic [3:0] KILL      = 4'b1111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_LUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_LUT    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } ctrl_state;

  // Wide enough to reach the largest hold count; the extra bit keeps a
  // hold of exactly 2^n representable.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ctrl_seq_cnt.sv
// Hold counter for EXEC/MEM: clear, load, increment, terminal compare.
module ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == term_val);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the accumulator datapath.
// Build option: CTRL_ILLEGAL_TRAP_EN turns opcode 15 into a halting trap with Err.
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// FETCH  | latch instruction, advance PC
// DECODE | route on latched opcode
// EXEC   | ALU busy, held for MUL/DIV cycle counts
// MEM    | data-memory read (LOA) or write (STR), held MEM_LAT cycles
// LUT    | lookup-table read
// WB     | one-cycle register-file write
// HALT   | program finished, Done held until Start
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8,
  parameter int MEM_LAT    = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [8:0] Instr,
  output logic       PcClr,
  output logic       PcInc,
  output logic       IrEn,
  output logic [3:0] AluOp,
  output logic       AluEn,
  output logic       RegWrEn,
  output logic [1:0] WbSel,
  output logic       MemRd,
  output logic       MemWr,
  output logic       LutRd,
  output logic       Done,
  output logic       Err,
  output logic [2:0] State
);

  localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES, MEM_LAT);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] MUL_HOLD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_HOLD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] MEM_HOLD = CW'(MEM_LAT);

  if (PC_W < 1 || MUL_CYCLES < 1 || DIV_CYCLES < 1 || MEM_LAT < 1) begin : g_param_check
    $error("ctrl_seq: PC_W and all hold counts must be >= 1");
  end

  ctrl_state state, state_nxt;
  logic [3:0]    opcode;
  logic [CW-1:0] cnt, hold;
  logic          cnt_term, cnt_load, cnt_inc, cnt_clr;
  logic          start_go;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^Instr[4:0];
  assign start_go = Start && !Reset && (state == ST_IDLE || state == ST_HALT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      opcode <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH) opcode <= Instr[8:5];
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q;
  always_ff @(posedge Clk) begin
    if (Reset || start_go) begin
      err_q <= 1'b0;
    end else if (state == ST_DECODE && opcode == KILL) begin
      err_q <= 1'b1;
    end
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_comb begin
    hold = ONE;
    if (state == ST_MEM)        hold = MEM_HOLD;
    else if (opcode == OP_MUL)  hold = MUL_HOLD;
    else if (opcode == OP_DIV)  hold = DIV_HOLD;
  end

  ctrl_cnt #(.W(CW)) u_cnt (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (ONE),
    .inc      (cnt_inc),
    .term_val (hold),
    .cnt      (cnt),
    .term     (cnt_term)
  );

  // PcClr is the one Start-dependent output: the PC is zeroed on the same
  // edge that enters FETCH, so the first fetch reads address 0.
  always_comb begin
    state_nxt = state;
    PcClr     = 1'b0;
    PcInc     = 1'b0;
    IrEn      = 1'b0;
    AluOp     = 4'd0;
    AluEn     = 1'b0;
    RegWrEn   = 1'b0;
    WbSel     = WB_ALU;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    LutRd     = 1'b0;
    Done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        Done    = (state == ST_HALT);
        cnt_clr = 1'b1;
        if (start_go) begin
          PcClr     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        IrEn      = 1'b1;
        PcInc     = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        cnt_load = 1'b1;
        case (opcode)
          OP_DONE:        state_nxt = ST_HALT;
          OP_LOA, OP_STR: state_nxt = ST_MEM;
          OP_LOOKUP:      state_nxt = ST_LUT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          KILL:           state_nxt = ST_HALT;
`else
          KILL:           state_nxt = ST_FETCH;
`endif
          default:        state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        AluEn = 1'b1;
        AluOp = opcode;
        if (cnt_term) state_nxt = ST_WB;
        else          cnt_inc   = 1'b1;
      end
      ST_MEM: begin
        MemRd = (opcode == OP_LOA);
        MemWr = (opcode != OP_LOA);
        if (cnt_term) state_nxt = (opcode == OP_LOA) ? ST_WB : ST_FETCH;
        else          cnt_inc   = 1'b1;
      end
      ST_LUT: begin
        LutRd     = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        RegWrEn   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_FETCH;
        if (opcode == OP_LOA)         WbSel = WB_MEM;
        else if (opcode == OP_LOOKUP) WbSel = WB_LUT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: builds the expected per-cycle output trace of a program from
// the instruction-level timing rules, then replays stimulus and compares every cycle.
module tb_ctrl_seq;

  localparam int PC_W  = 8;
  localparam int MUL_C = 3;
  localparam int DIV_C = 8;
  localparam int MEM_L = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Instr = '0;
  logic       PcClr, PcInc, IrEn, AluEn, RegWrEn, MemRd, MemWr, LutRd, Done, Err;
  logic [3:0] AluOp;
  logic [1:0] WbSel;
  logic [2:0] State;

  always #5 Clk = ~Clk;

  ctrl_seq #(.PC_W(PC_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .MEM_LAT(MEM_L)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr),
    .PcClr(PcClr), .PcInc(PcInc), .IrEn(IrEn), .AluOp(AluOp), .AluEn(AluEn),
    .RegWrEn(RegWrEn), .WbSel(WbSel), .MemRd(MemRd), .MemWr(MemWr), .LutRd(LutRd),
    .Done(Done), .Err(Err), .State(State)
  );

  typedef struct packed {
    logic       pcclr, pcinc, iren;
    logic [3:0] aluop;
    logic       aluen, regwren;
    logic [1:0] wbsel;
    logic       memrd, memwr, lutrd, done, err;
    logic [2:0] state;
  } vec_t;

  typedef struct {
    logic       rst, start, chk;
    logic [8:0] instr;
    vec_t       exp;
  } cyc_t;

  // State codes in the order the states are listed: IDLE FETCH DECODE EXEC MEM LUT WB HALT
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_LUT = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

  cyc_t tr[$];
  int   mode = 0;        // 0 idle, 1 running, 2 halted
  logic m_err = 1'b0;
  int   checks = 0;
  int   passed = 0;

  function automatic logic [8:0] junk();
    return 9'($urandom_range(0, 511));
  endfunction

  function automatic vec_t rest_vec();
    vec_t v = '0;
    if (mode == 2) begin
      v.done  = 1'b1;
      v.err   = m_err;
      v.state = S_HALT;
    end
    return v;
  endfunction

  function automatic void push(logic rst, logic start, logic [8:0] instr, logic chk, vec_t v);
    cyc_t c;
    c.rst = rst; c.start = start; c.instr = instr; c.chk = chk; c.exp = v;
    tr.push_back(c);
  endfunction

  function automatic void add_idle(int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, junk(), 1'b1, rest_vec());
  endfunction

  function automatic void add_reset(int n, logic first_known);
    for (int i = 0; i < n; i++) begin
      push(1'b1, 1'b0, junk(), (i > 0) || first_known, rest_vec());
      mode = 0;
      m_err = 1'b0;
    end
  endfunction

  function automatic void add_start();
    vec_t v = rest_vec();
    v.pcclr = 1'b1;
    push(1'b0, 1'b1, junk(), 1'b1, v);
    mode = 1;
    m_err = 1'b0;
  endfunction

  // Appends one instruction's cycles (FETCH onward); cut >= 0 asserts Reset in
  // that cycle and drops the rest. Returns the full FETCH-to-end cycle count.
  function automatic int add_instr(logic [3:0] op, logic [4:0] low, int cut);
    vec_t q[$];
    vec_t v;
    int   n, next_mode;
    logic trap_err = 1'b0;
    next_mode = 1;
    v = '0; v.state = S_FETCH; v.iren = 1'b1; v.pcinc = 1'b1; q.push_back(v);
    v = '0; v.state = S_DECODE; q.push_back(v);
    case (op)
      4'd13: next_mode = 2;
      4'd11: begin
        for (int i = 0; i < MEM_L; i++) begin v = '0; v.state = S_MEM; v.memrd = 1'b1; q.push_back(v); end
        v = '0; v.state = S_WB; v.regwren = 1'b1; v.wbsel = 2'd1; q.push_back(v);
      end
      4'd12: begin
        for (int i = 0; i < MEM_L; i++) begin v = '0; v.state = S_MEM; v.memwr = 1'b1; q.push_back(v); end
      end
      4'd14: begin
        v = '0; v.state = S_LUT; v.lutrd = 1'b1; q.push_back(v);
        v = '0; v.state = S_WB; v.regwren = 1'b1; v.wbsel = 2'd2; q.push_back(v);
      end
      4'd15: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        next_mode = 2;
        trap_err = 1'b1;
`endif
      end
      default: begin
        n = (op == 4'd3) ? MUL_C : (op == 4'd2) ? DIV_C : 1;
        for (int i = 0; i < n; i++) begin
          v = '0; v.state = S_EXEC; v.aluen = 1'b1; v.aluop = op; q.push_back(v);
        end
        v = '0; v.state = S_WB; v.regwren = 1'b1; v.wbsel = 2'd0; q.push_back(v);
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (cut >= 0 && i > cut) break;
      push(i == cut, ($urandom_range(0, 3) == 0), (i == 0) ? {op, low} : junk(), 1'b1, q[i]);
    end
    if (cut >= 0 && cut < q.size()) begin
      mode = 0;
      m_err = 1'b0;
    end else begin
      mode = next_mode;
      m_err = trap_err;
    end
    return q.size();
  endfunction

  task automatic pin(string name, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  initial begin
    int   l;
    int   n;
    int   cut;
    logic [3:0] op;
    vec_t act;

    // directed program
    add_reset(3, 1'b0);
    add_idle(2);
    add_start();
    l = add_instr(4'd1, 5'd3, -1);   pin("lat_add", l, 4);
    l = add_instr(4'd2, 5'd9, -1);   pin("lat_div", l, 11);
    l = add_instr(4'd11, 5'd1, -1);  pin("lat_loa", l, 5);
    l = add_instr(4'd12, 5'd2, -1);  pin("lat_str", l, 4);
    l = add_instr(4'd14, 5'd7, -1);  pin("lat_lookup", l, 4);
    l = add_instr(4'd13, 5'd0, -1);  pin("lat_done", l, 2);
    pin("halted_after_done", mode, 2);
    add_idle(20);
    add_start();
    l = add_instr(4'd3, 5'd4, -1);   pin("lat_mul", l, 6);
    l = add_instr(4'd2, 5'd5, 5);    // reset on 4th EXEC cycle of DIV
    pin("idle_after_reset", mode, 0);
    add_idle(3);
    add_start();
    l = add_instr(4'd15, 5'd31, -1); pin("lat_kill", l, 2);
    if (mode == 1) void'(add_instr(4'd13, 5'd0, -1));
    add_idle(4);

    // random programs
    for (int p = 0; p < 40; p++) begin
      if (mode != 1) begin
        add_idle($urandom_range(0, 3));
        add_start();
      end
      n = $urandom_range(3, 12);
      for (int k = 0; k < n && mode == 1; k++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd13) op = 4'd1;
        cut = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
        void'(add_instr(op, 5'($urandom_range(0, 31)), cut));
      end
      if (mode == 1) void'(add_instr(4'd13, 5'($urandom_range(0, 31)), -1));
      add_idle($urandom_range(0, 5));
    end

    // replay and compare
    foreach (tr[i]) begin
      @(posedge Clk);
      #1;
      Reset = tr[i].rst;
      Start = tr[i].start;
      Instr = tr[i].instr;
      @(negedge Clk);
      if (tr[i].chk) begin
        act = {PcClr, PcInc, IrEn, AluOp, AluEn, RegWrEn, WbSel, MemRd, MemWr, LutRd, Done, Err, State};
        checks++;
        if (act === tr[i].exp) passed++;
        else $display("FAIL cycle %0d outputs {clr,inc,ir,op,alu,wr,sel,rd,wrm,lut,done,err,st}: got %b want %b",
                      i, act, tr[i].exp);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
